apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer terminating transfers issued by the team's apb_master; backs a small word-addressed register file.
- Configurable wait-state insertion exercises master stall handling.
- Reports errors for bad, read-only and privilege-violating accesses.
- Used as the standard bus endpoint in APB subsystem benches, and as a control-register block in integration.

Parameters:
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, data width; multiple of 8.
- REG_NUM, 16, number of registers; power of 2, at least 4.
- WAIT_CYCLES, 1, access-phase cycles with pready low before completion; 0 to 15.
- ID_VALUE, 32'hA9B0_0001, constant value of reg 0.

Ports:
- pclk_i  in  1  clock.
- prstn_i  in  1  async active-low reset.
- paddr_i  in  ADDR_WIDTH  byte address.
- pprot_i  in  3  protection; bit0=1 means privileged.
- psel_i  in  1  select.
- penable_i  in  1  access phase.
- pwrite_i  in  1  1=write.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  DATA_WIDTH/8  byte strobes.
- pready_o  out  1  transfer complete.
- prdata_o  out  DATA_WIDTH  read data.
- pslverr_o  out  1  error response, valid with pready_o.

Behaviour:
- Clock and reset: one clock pclk_i; prstn_i is asynchronous, active-low.
- Reset values: pready_o=0, pslverr_o=0, prdata_o=0, all registers 0, state IDLE, cnt=0.
  - Reset asserted mid-transfer aborts the transfer; no register is updated.
- Index: idx = paddr_i[log2(REG_NUM)+1:2].
- Error (err), decided at setup (psel_i=1, penable_i=0) and latched with idx, pwrite_i and pprot_i[0]. err is set if any of:
  - paddr_i[1:0] != 0 (unaligned).
  - paddr_i[ADDR_WIDTH-1:log2(REG_NUM)+2] != 0 (out of range).
  - write to idx 0 (read-only ID register).
  - pprot_i[0]=0 and idx >= REG_NUM/2 (protected upper half).
- FSM states IDLE, WAIT, READY; all outputs registered.
  - IDLE: on setup, go READY if WAIT_CYCLES=0; otherwise go WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: pready_o=0. If psel_i=0 (abort), go IDLE with no side effects. Else if cnt=0, go READY; else cnt decrements.
  - READY: pready_o=1 for exactly one cycle, then IDLE. A setup in the cycle after READY is accepted normally (back-to-back).
- Access-phase length = WAIT_CYCLES+1 cycles.
- Read: on entry to READY, prdata_o = reg[idx] (ID_VALUE for idx 0) if not err, else 0. prdata_o returns to 0 in the cycle after READY.
- Write: committed at the clock edge ending the READY cycle, only if not err. Byte lane b updates only when pstrb_i[b]=1; pstrb_i=0 is a legal no-op.
- pslverr_o = latched err during READY; 0 otherwise.
- No register changes on any errored transfer.
- penable_i high without a preceding setup while in IDLE: ignored, no response.

Test Plan:
- WAIT_CYCLES=0: write 0x12345678 to addr 0x4, then read 0x4 -> each access phase is 1 cycle with pready=1; read returns 0x12345678; pslverr=0.
- WAIT_CYCLES=3: read addr 0x0 -> pready low for 3 access cycles, high on the 4th; prdata=0xA9B00001.
- Strobes: reg 2 = 0xFFFFFFFF; write 0x00000000 with pstrb=4'b0101 -> reading reg 2 returns 0xFF00FF00.
- Errors, each with pslverr=1 and no register change: write addr 0x0; read 0x6; read 0x40; write 0x20 with pprot=0. Read of 0x20 with pprot=1 -> pslverr=0.
- Back-to-back, random WAIT_CYCLES 0..5: 200 random read/write transfers -> scoreboard match, no lost or duplicated pready pulses.
- Abort and reset: drop psel during WAIT -> next write proceeds normally. Assert prstn mid-write -> all outputs and registers read back 0.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the apb_slave_regfile completer.
// Signal names keep the completer's port-direction suffixes so both sides read the same.
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr_i;
  logic [2:0]            pprot_i;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [STRB_W-1:0]     pstrb_i;
  logic                  pready_o;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pslverr_o;

  modport master (
    output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backing a word-addressed register file with configurable wait states,
// a read-only ID register at index 0 and a privileged-only upper half.
module apb_slave_regfile #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           REG_NUM     = 16,
  parameter int unsigned           WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
  input logic               pclk_i,
  input logic               prstn_i,
  apb_slave_regfile_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(REG_NUM);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

  logic             setup_c;
  logic [IDX_W-1:0] idx_c;
  logic             err_c;
  logic             unused_prot;

  assign unused_prot = ^bus.pprot_i[2:1];

  // Setup-phase decode: address index and every error source, latched on acceptance.
  assign setup_c = bus.psel_i & ~bus.penable_i;
  assign idx_c   = bus.paddr_i[IDX_W+1:2];
  assign err_c   = (bus.paddr_i[1:0] != 2'b00)
                 | ((bus.paddr_i >> (IDX_W + 2)) != '0)
                 | (bus.pwrite_i & (idx_c == '0))
                 | (~bus.pprot_i[0] & idx_c[IDX_W-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    regs_d    = regs_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          idx_d = idx_c;
          wr_d  = bus.pwrite_i;
          err_d = err_c;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!bus.psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        state_d = ST_IDLE;
        // Write lands on the edge closing the completion cycle, lane by lane.
        if (wr_q && !err_q) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (bus.pstrb_i[b]) regs_d[idx_q][8*b +: 8] = bus.pwdata_i[8*b +: 8];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_READY) begin
      pready_d  = 1'b1;
      pslverr_d = err_d;
      if (!wr_d && !err_d) prdata_d = (idx_d == '0) ? ID_VALUE : regs_q[idx_d];
    end
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= regs_d[r];
    end
  end

  assign bus.pready_o  = pready_q;
  assign bus.pslverr_o = pslverr_q;
  assign bus.prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: six instances with WAIT_CYCLES 0..5 share the bus signals
// but each has its own psel; a per-instance array model predicts data, errors and latency.
module tb_apb_slave_regfile;

  localparam int NDUT = 6;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk;
  logic        rstn;
  logic [NDUT-1:0] psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [NDUT-1:0] pready_v;
  logic [NDUT-1:0] pslverr_v;
  logic [31:0]     prdata_v [NDUT];

  logic [31:0] mdl [NDUT][16];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar w = 0; w < NDUT; w++) begin : g_dut
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.paddr_i   = paddr;
    assign bus.pprot_i   = pprot;
    assign bus.psel_i    = psel[w];
    assign bus.penable_i = penable;
    assign bus.pwrite_i  = pwrite;
    assign bus.pwdata_i  = pwdata;
    assign bus.pstrb_i   = pstrb;
    assign pready_v[w]   = bus.pready_o;
    assign pslverr_v[w]  = bus.pslverr_o;
    assign prdata_v[w]   = bus.prdata_o;
    apb_slave_regfile #(.WAIT_CYCLES(w)) u_dut (
      .pclk_i (clk),
      .prstn_i(rstn),
      .bus    (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int r = 0; r < 16; r++) mdl[d][r] = 32'h0;
  endtask

  // Drives one transfer; called at posedge+1 with the bus free. Returns with psel released.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int acc);
    logic [NDUT-1:0] others;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge clk); #1;
    penable = 1'b1;
    acc = 1;
    while (pready_v[d] !== 1'b1 && acc < 40) begin
      @(posedge clk); #1;
      acc++;
    end
    rd = prdata_v[d];
    er = pslverr_v[d];
    others = pready_v;
    others[d] = 1'b0;
    chk("pready_other_dut", 32'(others), 32'h0);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    chk("pready_single_pulse", 32'(pready_v[d]), 32'h0);
    chk("prdata_back_to_zero", prdata_v[d], 32'h0);
  endtask

  // Transfer checked against the model; the model applies writes after the compare.
  task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                         input string tag, output logic [31:0] rd);
    int          idx;
    logic        e;
    logic [31:0] exp_rd;
    logic        er;
    int          acc;
    idx = int'(addr[5:2]);
    e = (addr[1:0] != 2'b00) || (addr[31:6] != 26'h0) || (wr && idx == 0) ||
        (!pr[0] && idx >= 8);
    exp_rd = 32'h0;
    if (!wr && !e) exp_rd = (idx == 0) ? ID : mdl[d][idx];
    xfer(d, wr, addr, wd, st, pr, rd, er, acc);
    chk({tag, "_pslverr"}, 32'(er), 32'(e));
    chk({tag, "_access_cycles"}, 32'(acc), 32'(d + 1));
    if (!wr) chk({tag, "_prdata"}, rd, exp_rd);
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          quiet;
    rstn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    clear_model();
    #12;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_pready", 32'(pready_v[d]), 32'h0);
      chk("reset_pslverr", 32'(pslverr_v[d]), 32'h0);
      chk("reset_prdata", prdata_v[d], 32'h0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: write then read back
    do_xfer(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 3'b001, "w0_write", rd);
    do_xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, "w0_read", rd);
    chk("w0_read_literal", rd, 32'h1234_5678);

    // Three wait states: ID register
    do_xfer(3, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, "w3_id", rd);
    chk("w3_id_literal", rd, ID);

    // Byte strobes
    do_xfer(1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 3'b001, "strb_fill", rd);
    do_xfer(1, 1'b1, 32'h8, 32'h0000_0000, 4'b0101, 3'b001, "strb_part", rd);
    do_xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, "strb_read", rd);
    chk("strb_read_literal", rd, 32'hFF00_FF00);
    do_xfer(1, 1'b1, 32'h8, 32'h1234_5678, 4'b0000, 3'b001, "strb_none", rd);
    do_xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b001, "strb_none_read", rd);

    // Error responses leave registers untouched
    do_xfer(2, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 3'b001, "priv_write", rd);
    do_xfer(2, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'b001, "err_wr_id", rd);
    do_xfer(2, 1'b0, 32'h6, 32'h0, 4'hF, 3'b001, "err_unaligned", rd);
    do_xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, 3'b001, "err_range", rd);
    do_xfer(2, 1'b1, 32'h20, 32'h0, 4'hF, 3'b000, "err_unpriv", rd);
    do_xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, "priv_read", rd);
    chk("priv_read_literal", rd, 32'hCAFE_F00D);
    do_xfer(2, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, "id_read_unpriv", rd);

    // penable without setup in idle is ignored
    psel = '0; psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4; pprot = 3'b001;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (pready_v[0] !== 1'b0) quiet++;
    end
    chk("penable_no_setup_quiet", 32'(quiet), 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge clk); #1;

    // Abort during wait states
    do_xfer(3, 1'b1, 32'h10, 32'h1111_1111, 4'hF, 3'b001, "abort_pre", rd);
    psel = '0; psel[3] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'h2222_2222; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (pready_v[3] !== 1'b0) quiet++;
    end
    chk("abort_no_pready", 32'(quiet), 32'h0);
    do_xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, "abort_unchanged", rd);
    do_xfer(3, 1'b1, 32'h10, 32'h3333_3333, 4'hF, 3'b001, "abort_next_wr", rd);
    do_xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, "abort_next_rd", rd);

    // Randomized back-to-back traffic across all wait-state settings
    for (int n = 0; n < 200; n++) begin
      int          d;
      int          bitpos;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  pr;
      d = $urandom_range(0, NDUT - 1);
      wr = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) begin
        bitpos = $urandom_range(6, 31);
        addr[bitpos] = 1'b1;
      end
      pr = 3'($urandom);
      pr[0] = ($urandom_range(0, 3) != 0);
      do_xfer(d, wr, addr, $urandom, 4'($urandom), pr, "rand", rd);
    end

    // Reset in the middle of a write
    psel = '0; psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h14; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    chk("midrst_pready", 32'(pready_v[2]), 32'h0);
    chk("midrst_pslverr", 32'(pslverr_v[2]), 32'h0);
    chk("midrst_prdata", prdata_v[2], 32'h0);
    psel = '0; penable = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int r = 1; r < 16; r++)
      do_xfer(2, 1'b0, 32'(r) << 2, 32'h0, 4'hF, 3'b001, "post_rst", rd);
    do_xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, "post_rst_w0", rd);
    do_xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, "post_rst_w3", rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
